// File: rtl/ucaspian_pkg.sv
// Shared types and helpers for the ucaspian neuromorphic datapath.
package ucaspian_pkg;

  localparam int CHARGE_WIDTH_DEF = 16;
  localparam int NEURON_AW        = 8;
  localparam int DEND_CHARGE_W    = 9;

  typedef enum logic [2:0] {ACCUM, FLUSH, SCAN, OUT, DONE} dend_state_e;

  // Signed add of two 32-bit operands, clamped to the range of a w-bit signed value.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) begin
      return hi[31:0];
    end else if (s < lo) begin
      return lo[31:0];
    end
    return s[31:0];
  endfunction

endpackage

// File: rtl/dendrite_charge_ram.sv
// Per-neuron charge storage: one write port, one registered read port.
// A read that collides with a write to the same address returns the old contents.
module dendrite_charge_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dendrite_accum.sv
// Accumulates signed fire charge per neuron and drains touched neurons in address order.
module dendrite_accum
  import ucaspian_pkg::*;
#(
  parameter int CHARGE_WIDTH = CHARGE_WIDTH_DEF,
  parameter int MAX_ADDR     = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NEURON_AW-1:0]           dend_addr,
  input  logic signed [DEND_CHARGE_W-1:0] dend_charge,
  input  logic                           dend_vld,
  output logic                           dend_rdy,
  input  logic                           drain_start,
  output logic [NEURON_AW-1:0]           neuron_addr,
  output logic signed [CHARGE_WIDTH-1:0] neuron_charge,
  output logic                           neuron_vld,
  input  logic                           neuron_rdy,
  output logic                           drain_done,
  output logic                           busy
);

  localparam int DEPTH = MAX_ADDR + 1;
  localparam logic [NEURON_AW-1:0] LAST_ADDR = NEURON_AW'(MAX_ADDR);

  dend_state_e                    state_q, state_d;
  logic [NEURON_AW-1:0]           scan_addr_q, scan_addr_d;
  logic [DEPTH-1:0]               active_q, active_d;

  logic                           s1_vld_q;
  logic [NEURON_AW-1:0]           s1_addr_q;
  logic signed [DEND_CHARGE_W-1:0] s1_charge_q;
  logic                           last_wr_q;
  logic [NEURON_AW-1:0]           last_addr_q;
  logic signed [CHARGE_WIDTH-1:0] last_sum_q;

  logic                           accept;
  logic                           fwd;
  logic signed [CHARGE_WIDTH-1:0] ram_rdata;
  logic signed [CHARGE_WIDTH-1:0] old_val;
  logic signed [CHARGE_WIDTH-1:0] sum_val;
  logic                           ram_re;
  logic [NEURON_AW-1:0]           ram_raddr;

  assign accept = dend_vld && dend_rdy;

  // The RAM still holds the pre-write value for a back-to-back hit, so take the last sum instead.
  assign fwd     = last_wr_q && (last_addr_q == s1_addr_q);
  assign old_val = fwd ? last_sum_q : (active_q[s1_addr_q] ? ram_rdata : '0);
  assign sum_val = CHARGE_WIDTH'(sat_add(32'(old_val), 32'(s1_charge_q), CHARGE_WIDTH));

  assign ram_raddr = (state_q == ACCUM) ? dend_addr : scan_addr_q;
  assign ram_re    = accept || ((state_q == SCAN) && active_q[scan_addr_q]);

  dendrite_charge_ram #(
    .DEPTH(DEPTH),
    .WIDTH(CHARGE_WIDTH),
    .AW   (NEURON_AW)
  ) u_ram (
    .clk    (clk),
    .we_i   (s1_vld_q),
    .waddr_i(s1_addr_q),
    .wdata_i(sum_val),
    .re_i   (ram_re),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (drain_start) state_d = FLUSH;
      FLUSH: if (!s1_vld_q && !last_wr_q) state_d = SCAN;
      SCAN: begin
        if (active_q[scan_addr_q])        state_d = OUT;
        else if (scan_addr_q == LAST_ADDR) state_d = DONE;
      end
      OUT:   if (neuron_rdy) state_d = (scan_addr_q == LAST_ADDR) ? DONE : SCAN;
      DONE:  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    dend_rdy      = 1'b0;
    neuron_vld    = 1'b0;
    neuron_addr   = '0;
    neuron_charge = '0;
    drain_done    = 1'b0;
    busy          = (state_q != ACCUM) || s1_vld_q || last_wr_q;
    case (state_q)
      ACCUM: dend_rdy = !reset;
      OUT: begin
        neuron_vld    = 1'b1;
        neuron_addr   = scan_addr_q;
        neuron_charge = ram_rdata;
      end
      DONE:  drain_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    scan_addr_d = scan_addr_q;
    active_d    = active_q;
    if (s1_vld_q) active_d[s1_addr_q] = 1'b1;
    case (state_q)
      FLUSH: scan_addr_d = '0;
      SCAN: begin
        if (!active_q[scan_addr_q] && (scan_addr_q != LAST_ADDR)) scan_addr_d = scan_addr_q + 1'b1;
      end
      OUT: begin
        if (neuron_rdy) begin
          active_d[scan_addr_q] = 1'b0;
          if (scan_addr_q != LAST_ADDR) scan_addr_d = scan_addr_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_addr_q <= '0;
      active_q    <= '0;
      s1_vld_q    <= 1'b0;
      s1_addr_q   <= '0;
      s1_charge_q <= '0;
      last_wr_q   <= 1'b0;
      last_addr_q <= '0;
      last_sum_q  <= '0;
    end else begin
      scan_addr_q <= scan_addr_d;
      active_q    <= active_d;
      s1_vld_q    <= accept;
      if (accept) begin
        s1_addr_q   <= dend_addr;
        s1_charge_q <= dend_charge;
      end
      last_wr_q <= s1_vld_q;
      if (s1_vld_q) begin
        last_addr_q <= s1_addr_q;
        last_sum_q  <= sum_val;
      end
    end
  end

endmodule

// File: tb/tb_dendrite_accum.sv
// Self-checking bench for dendrite_accum against a per-neuron saturating sum model.
module tb_dendrite_accum;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        dend_addr;
  logic signed [8:0] dend_charge;
  logic              dend_vld;
  logic              dend_rdy;
  logic              drain_start;
  logic [7:0]        neuron_addr;
  logic signed [15:0] neuron_charge;
  logic              neuron_vld;
  logic              neuron_rdy;
  logic              drain_done;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int mdl_sum [256];
  bit mdl_act [256];

  always #5 clk = ~clk;

  dendrite_accum dut (
    .clk          (clk),
    .reset        (reset),
    .dend_addr    (dend_addr),
    .dend_charge  (dend_charge),
    .dend_vld     (dend_vld),
    .dend_rdy     (dend_rdy),
    .drain_start  (drain_start),
    .neuron_addr  (neuron_addr),
    .neuron_charge(neuron_charge),
    .neuron_vld   (neuron_vld),
    .neuron_rdy   (neuron_rdy),
    .drain_done   (drain_done),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mdl_add(input int a, input int c);
    int s;
    s = mdl_sum[a] + c;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    mdl_sum[a] = s;
    mdl_act[a] = 1'b1;
  endtask

  task automatic mdl_clear();
    for (int a = 0; a < 256; a++) begin
      mdl_sum[a] = 0;
      mdl_act[a] = 1'b0;
    end
  endtask

  // Called at a negedge; presents one fire for the following posedge.
  task automatic send(input int a, input int c);
    dend_vld    = 1'b1;
    dend_addr   = 8'(a);
    dend_charge = 9'(c);
    chk("dend_rdy_accum", dend_rdy, 1);
    mdl_add(a, c);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    dend_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // mode 0: neuron_rdy always 1, 1: toggling, 2: random
  task automatic do_drain(input bit with_fire, input int fa, input int fc, input int mode, output int cycles);
    int  exp_a[$];
    int  exp_c[$];
    int  cyc;
    int  n_out;
    bit  done;
    bit  hold;
    bit  r;
    logic [7:0]         ha;
    logic signed [15:0] hc;
    drain_start = 1'b1;
    dend_vld    = with_fire;
    dend_addr   = 8'(fa);
    dend_charge = 9'(fc);
    if (with_fire) begin
      chk("fire_with_drain_rdy", dend_rdy, 1);
      mdl_add(fa, fc);
    end
    for (int a = 0; a < 256; a++) begin
      if (mdl_act[a]) begin
        exp_a.push_back(a);
        exp_c.push_back(mdl_sum[a]);
      end
    end
    mdl_clear();
    @(negedge clk);
    drain_start = 1'b0;
    // An upstream fire held during the drain must not be taken.
    dend_vld    = 1'b1;
    dend_addr   = 8'd77;
    dend_charge = 9'sd1;
    cyc = 0; n_out = 0; done = 1'b0; hold = 1'b0; ha = '0; hc = '0;
    while (!done && cyc < 3000) begin
      cyc++;
      chk("dend_rdy_drain", dend_rdy, 0);
      chk("busy_drain", busy, 1);
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2) == 0;
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (neuron_vld) begin
        if (hold) begin
          chk("hold_addr", neuron_addr, ha);
          chk("hold_charge", neuron_charge, hc);
        end
        if (r) begin
          if (exp_a.size() == 0) begin
            chk("extra_output_addr", neuron_addr, -1);
          end else begin
            chk("out_addr", neuron_addr, exp_a.pop_front());
            chk("out_charge", neuron_charge, exp_c.pop_front());
            $display("drain out #%0d addr=%0d charge=%0d", n_out, neuron_addr, neuron_charge);
            n_out++;
          end
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          ha   = neuron_addr;
          hc   = neuron_charge;
        end
      end
      neuron_rdy = r;
      if (drain_done) begin
        done = 1'b1;
        chk("vld_at_done", neuron_vld, 0);
      end
      @(negedge clk);
    end
    dend_vld   = 1'b0;
    neuron_rdy = 1'b0;
    chk("drain_done_seen", done, 1);
    chk("drain_missing_outputs", exp_a.size(), 0);
    chk("done_one_cycle", drain_done, 0);
    chk("rdy_after_drain", dend_rdy, 1);
    cycles = cyc;
    $display("drain complete: %0d outputs, %0d cycles", n_out, cyc);
  endtask

  initial begin
    int cyc;
    int n;
    mdl_clear();
    reset = 1'b1; dend_addr = '0; dend_charge = '0; dend_vld = 1'b0;
    drain_start = 1'b0; neuron_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dend_rdy", dend_rdy, 0);
    chk("rst_neuron_vld", neuron_vld, 0);
    chk("rst_neuron_charge", neuron_charge, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", dend_rdy, 1);

    // Single fire
    send(5, 10);
    chk("busy_pipeline", busy, 1);
    idle(2);
    do_drain(1'b0, 0, 0, 0, cyc);

    // Back-to-back fires to one address
    send(3, 100); send(3, -20); send(3, 7);
    idle(2);
    do_drain(1'b0, 0, 0, 0, cyc);

    // Saturation in both directions
    for (int i = 0; i < 400; i++) send(0, 127);
    for (int i = 0; i < 200; i++) send(1, -256);
    idle(2);
    do_drain(1'b0, 0, 0, 1, cyc);

    // Ordering with stalled consumer, then an empty drain
    send(255, 33); send(1, -9); send(200, 250);
    idle(2);
    do_drain(1'b0, 0, 0, 1, cyc);
    do_drain(1'b0, 0, 0, 0, cyc);
    chk("empty_drain_cycles", cyc, 258);

    // Fire accepted on the drain_start cycle
    do_drain(1'b1, 9, -4, 0, cyc);

    // Reset while presenting an output
    send(1, 5); send(2, 6);
    idle(2);
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    neuron_rdy  = 1'b0;
    for (int i = 0; i < 50 && !neuron_vld; i++) @(negedge clk);
    chk("rst_test_out_reached", neuron_vld, 1);
    chk("rst_test_out_addr", neuron_addr, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_vld", neuron_vld, 0);
    chk("rst_mid_done", drain_done, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    mdl_clear();
    @(negedge clk);
    do_drain(1'b0, 0, 0, 0, cyc);
    chk("post_rst_drain_cycles", cyc, 258);

    // Randomised rounds
    for (int rnd = 0; rnd < 8; rnd++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        int a;
        int c;
        a = (rnd % 2 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
        c = $urandom_range(0, 511) - 256;
        send(a, c);
        if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 1) begin
        do_drain(1'b1, $urandom_range(0, 255), $urandom_range(0, 511) - 256, 2, cyc);
      end else begin
        idle($urandom_range(0, 2));
        do_drain(1'b0, 0, 0, 2, cyc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dendrite_accum.md
Name: dendrite_accum

Overview:
- Consumer end of the single-dendrite fire stream: accepts (addr, signed charge) transfers on a valid/ready handshake and accumulates charge per neuron into a 256-entry charge memory.
- On a drain request at end of timestep, scans all touched neurons in ascending address order and emits each accumulated charge to the neuron unit, clearing it as it goes.
- Sits between the synapse/incoming fire merge and the neuron unit.

Parameters:
- CHARGE_WIDTH, 16, signed width of each accumulated charge entry and of neuron_charge.
- MAX_ADDR, 255, highest neuron address scanned during drain (0..MAX_ADDR).

Ports:
- clk  input  1  single clock.
- reset  input  1  reset, asynchronous, active-high.
- dend_addr  input  8  target neuron address.
- dend_charge  input  9  signed charge increment (two's complement).
- dend_vld  input  1  fire valid.
- dend_rdy  output  1  accumulator can accept a fire.
- drain_start  input  1  single-cycle pulse requesting drain.
- neuron_addr  output  8  drained neuron address.
- neuron_charge  output  CHARGE_WIDTH  drained accumulated charge, signed.
- neuron_vld  output  1  drained entry valid.
- neuron_rdy  input  1  neuron unit accepts entry.
- drain_done  output  1  one-cycle pulse when drain completes.
- busy  output  1  high in any state other than ACCUM, or while the pipeline is non-empty.

Behaviour:
- Reset (async): state=ACCUM; active bitmap (256 flops) cleared; pipeline valid cleared; all outputs 0. Memory contents are not cleared; an inactive entry reads as 0.
- ACCUM: dend_rdy=1. A transfer occurs when dend_vld&&dend_rdy.
- Pipeline stage 1: register addr/charge; issue synchronous RAM read.
- Pipeline stage 2: old = forward ? last_sum : (active[addr] ? ram_q : 0); sum = sat(old + sign_extend(charge)); write RAM; set active[addr]; register last_addr/last_sum/last_wr.
- Forward when last_wr && last_addr==addr. Throughput is 1 fire/cycle, and back-to-back fires to the same address must accumulate correctly. RAM has read-old-on-collision semantics.
- Saturation: clamp to [-2^(CHARGE_WIDTH-1), 2^(CHARGE_WIDTH-1)-1], i.e. [-32768, 32767] at default width.
- drain_start in ACCUM: a transfer on the same cycle is accepted and included in the drain. Next state FLUSH, dend_rdy=0 from the next cycle. drain_start outside ACCUM is ignored.
- FLUSH: wait until stage 1 and stage 2 are empty, then scan_addr=0 and go to SCAN.
- SCAN: if active[scan_addr], issue RAM read and go to OUT. Otherwise, if scan_addr==MAX_ADDR go to DONE, else increment scan_addr. Each inactive address costs one cycle.
- OUT: neuron_vld=1, neuron_addr=scan_addr, neuron_charge=RAM read data (held stable while neuron_rdy=0).
- On neuron_rdy in OUT: clear active[scan_addr]; if scan_addr==MAX_ADDR go to DONE, else increment scan_addr and go to SCAN.
- DONE: drain_done=1 for exactly one cycle, then ACCUM.
- dend_vld during FLUSH, SCAN, OUT or DONE: dend_rdy=0; the upstream holds the transfer.
- Async reset mid-drain: outputs drop immediately; all pending charge is discarded.
- Drain with no active entries: MAX_ADDR+1 SCAN cycles, no neuron_vld, then drain_done.

Decomposition:
- Shared package ucaspian_pkg:
  - CHARGE_WIDTH default.
  - Neuron address width (8).
  - State enum {ACCUM, FLUSH, SCAN, OUT, DONE}.
  - Saturating signed add function.
- One sub-module, dendrite_charge_ram: (MAX_ADDR+1) x CHARGE_WIDTH, one write port, one synchronous read port, read-old on collision, inferable as block RAM.

Test Plan:
- Reset, fire addr 5 charge +10, drain_start with neuron_rdy=1 -> single output addr 5 charge 10, then drain_done pulse; no other neuron_vld.
- Consecutive-cycle fires to addr 3 of +100, -20, +7, then drain -> addr 3 charge 87, with dend_rdy high throughout the fires (forwarding path).
- 400 fires of +127 to addr 0 and 200 fires of -256 to addr 1, then drain -> addr 0 charge 32767, addr 1 charge -32768.
- Fires to addrs 255, 1, 200; drain with neuron_rdy toggling 0/1 -> outputs in order 1, 200, 255, each held stable while neuron_rdy=0.
  - dend_rdy stays 0 until drain_done.
  - An immediate second drain emits nothing and pulses drain_done after 256 scan cycles.
- drain_start on the same cycle as an accepted fire addr 9 charge -4 -> that entry is drained as addr 9 charge -4.
- Assert reset while in OUT for addr 1 of {1: +5, 2: +6} -> neuron_vld=0 immediately; after release, a drain emits nothing.
